// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment display: hex decode table and
// active-low polarity values for segments, decimal point and anodes.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       DP_ON     = 1'b0;
    localparam logic       DP_OFF    = 1'b1;
    localparam logic       AN_ON     = 1'b0;
    localparam logic       AN_OFF    = 1'b1;

    // {g,f,e,d,c,b,a}, active-low; entry 0 is the least significant slice.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] hex);
        return SEG_LUT[hex];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_of(hex_i);

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed multi-digit 7-segment driver with frame-synchronous load,
// leading-zero blanking and whole-display blink.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_LOG2 = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] din_i,
    input  logic [NUM_DIGITS-1:0]   dp_in_i,
    input  logic                    blank_lz_i,
    input  logic                    blink_en_i,
    output logic [6:0]              seg7_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_start_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                    pending_q, pending_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BLINK_LOG2-1:0]   blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fs_q, fs_d;

    logic                    presc_wrap, boundary;
    logic [3:0]              digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz;
    logic                    all_zero;
    logic [6:0]              seg_dec;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign digits[g] = active_q[4*g +: 4];
    end

    hex_to_seg7 u_dec (
        .hex_i (digits[idx_q]),
        .seg_o (seg_dec)
    );

    assign presc_wrap = (presc_q == PRE_LAST);
    assign boundary   = presc_wrap && (idx_q == IDX_LAST);

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz       = '0;
        all_zero = blank_lz_i;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (digits[i] == 4'h0);
            lz[i]    = all_zero;
        end
    end

    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pending_d   = pending_q;
        presc_d     = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        if (presc_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

        // Transfer uses the pre-edge shadow, so a load on the boundary waits a frame.
        if (boundary && pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
            pending_d   = 1'b0;
        end
        if (load_i) begin
            shadow_d    = din_i;
            shadow_dp_d = dp_in_i;
            pending_d   = 1'b1;
        end

        if (!blink_en_i) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (boundary) begin
            blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
            if (&blink_cnt_q) phase_d = ~phase_q;
        end

        seg_d = lz[idx_q] ? SEG_BLANK : seg_dec;
        dp_d  = lz[idx_q] ? DP_OFF : (active_dp_q[idx_q] ? DP_ON : DP_OFF);
        an_d  = (blink_en_i && !phase_q) ? {NUM_DIGITS{AN_OFF}} : ~(AN_ONE << idx_q);
        fs_d  = (presc_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            pending_q   <= 1'b0;
            presc_q     <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            seg_q       <= SEG_BLANK;
            dp_q        <= DP_OFF;
            an_q        <= {NUM_DIGITS{AN_OFF}};
            fs_q        <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            pending_q   <= pending_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fs_q        <= fs_d;
        end
    end

    assign seg7_o        = seg_q;
    assign dp_o          = dp_q;
    assign an_o          = an_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboarded bench: a slot-based reference model queues the expected pins
// for every clock; a monitor on the falling edge compares them.
module tb_seg7_scan_display;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BL = 1;
    localparam int F  = N * SD;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } obs_t;

    logic         clk, rst, load, blank_lz, blink_en;
    logic [15:0]  din;
    logic [3:0]   dp_in;
    logic [6:0]   seg7;
    logic         dp, frame_start;
    logic [3:0]   an;

    obs_t         expq [$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           nxt = 0;

    seg7_scan_display #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLINK_LOG2 (BL)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .load_i        (load),
        .din_i         (din),
        .dp_in_i       (dp_in),
        .blank_lz_i    (blank_lz),
        .blink_en_i    (blink_en),
        .seg7_o        (seg7),
        .dp_o          (dp),
        .an_o          (an),
        .frame_start_o (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model. Slot s counts clocks since reset release; slot s shows
    // digit (s/SD)%N of frame s/F, whose data is the last load made at or
    // before slot s/F*F-2. Blink phase is off when floor(boundaries/2^BL) is odd.
    initial begin
        obs_t        e;
        int          s, d, nb;
        logic [19:0] shown, hist1, hist2;
        logic        lz, phase_on;
        nb = 0; shown = '0; hist1 = '0; hist2 = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};
                nxt = 0; nb = 0; shown = '0; hist1 = '0; hist2 = '0;
            end else begin
                s = nxt;
                if (s % F == 0 && s > 0) shown = hist2;
                d = (s / SD) % N;
                lz = blank_lz && (d != 0) && ((shown[15:0] >> (4 * d)) == 16'h0);
                phase_on = (((nb >> BL) & 1) == 0);
                e.seg = lz ? 7'h7F : SEGTAB[shown[4*d +: 4]];
                e.dp  = lz ? 1'b1 : ~shown[16 + d];
                e.an  = (blink_en && !phase_on) ? 4'hF : ~(4'b0001 << d);
                e.fs  = (s % F == 0);
                if (!blink_en) nb = 0;
                else if (s % F == F - 1) nb++;
                hist2 = hist1;
                if (load) hist1 = {dp_in, din};
                nxt = s + 1;
            end
            expq.push_back(e);
        end
    end

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            n_chk++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = expq.pop_front();
                if ({seg7, dp, an, frame_start} !== e) begin
                    n_fail++;
                    $display("FAIL pins t=%0t got seg7=%h dp=%b an=%h fs=%b want seg7=%h dp=%b an=%h fs=%b",
                             $time, seg7, dp, an, frame_start, e.seg, e.dp, e.an, e.fs);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        load = 1'b1; din = v; dp_in = p;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; din = '0; dp_in = '0; blank_lz = 1'b0; blink_en = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        do_load(16'h12AF, 4'h0);
        cyc(3 * F);
        // two loads in one frame, last wins
        do_load(16'h1111, 4'h0);
        cyc(2);
        do_load(16'h2222, 4'h0);
        cyc(2 * F);
        // load issued on the boundary slot itself
        for (int i = 0; i < F && (nxt % F) != F - 1; i++) cyc(1);
        do_load(16'h3456, 4'h0);
        cyc(2 * F);
        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        cyc(2 * F);
        do_load(16'h0000, 4'h0);
        cyc(2 * F);
        do_load(16'h0050, 4'b0100);
        cyc(2 * F);
        blank_lz = 1'b0;
        cyc(2 * F);
        // reset mid-scan discards a pending load
        cyc(5);
        do_load(16'h9999, 4'hF);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2 * F);
        blink_en = 1'b1;
        cyc(10 * F + 3);
        blink_en = 1'b0;
        cyc(F);
        repeat (2000) begin
            load  = ($urandom_range(7) == 0);
            din   = 16'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(63) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(127) == 0) blink_en = ~blink_en;
            rst   = ($urandom_range(499) == 0);
            if ($urandom_range(3) == 0) din = din & 16'h00FF;
            cyc(1);
        end
        rst = 1'b0; load = 1'b0;
        cyc(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver. Successor to the single-digit registered 3-bit decoder.
- Holds NUM_DIGITS 4-bit hex values in shadow and active registers.
- Scans one digit at a time with a clock prescaler and drives shared active-low segments plus per-digit active-low anodes.
- Adds a frame-synchronous (tear-free) load, leading-zero blanking and a blink mode. Sits between datapath result registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 1..8).
- SCAN_DIV, 1000, Clock cycles each digit is lit (legal >= 2).
- BLINK_LOG2, 6, blink phase toggles every 2^BLINK_LOG2 complete frames.

Ports:
- Clock  in  1  system clock, all state on posedge.
- Reset  in  1  synchronous, active-high reset.
- load  in  1  capture din/dp_in into the shadow registers this cycle.
- din  in  4*NUM_DIGITS  packed hex digits; digit i = din[4i+3:4i]; digit 0 = rightmost/LSD.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  1 = blank leading zeros.
- blink_en  in  1  1 = blink the whole display.
- seg7  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- an  out  NUM_DIGITS  active-low one-hot digit enable.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- Reset values:
  - shadow, active and dp registers = 0; pending flag = 0.
  - prescaler = 0, digit index = 0, blink counter = 0, blink phase = on.
  - Outputs: seg7 = 7'h7F, dp = 1, an = all ones, frame_start = 0.
- Reset applies in any state and aborts a pending load; the pending value is discarded.
- Prescaler: counts 0..SCAN_DIV-1 and is $clog2(SCAN_DIV) bits wide. When it reaches SCAN_DIV-1, it returns to 0 and the digit index advances.
- Digit index wraps from NUM_DIGITS-1 to 0. A frame is NUM_DIGITS*SCAN_DIV cycles. With NUM_DIGITS = 1 the index stays at 0 and every wrap is a frame boundary.
- Load:
  - load = 1 captures din/dp_in into shadow and sets pending.
  - At the frame boundary (the cycle the index wraps to 0), if pending is set: active <= shadow, pending <= 0.
  - Several loads within one frame: the last one wins.
  - Load on the boundary cycle itself: the captured value is new shadow and pending stays 1. The old shadow transfers to active and the new value transfers at the next boundary.
- Output timing: seg7, dp, an and frame_start are registered, so they lag the digit index by 1 cycle. The first digit-0 display appears on the first cycle after Reset is released.
- Decode (active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
- Leading-zero blanking: with blank_lz = 1, digit i is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg7 = 7'h7F and dp = 1, but its anode is still driven.
- Blink:
  - The blink counter increments once per frame boundary.
  - The phase toggles when the counter wraps at 2^BLINK_LOG2.
  - With blink_en = 1 and phase off, an = all ones.
  - blink_en = 0 forces the phase on and clears the counter.
- frame_start: asserted in the same cycle an first shows digit 0.

Decomposition:
- Shared package (seg7_pkg):
  - 16-entry hex-to-segment constant table.
  - SEG_BLANK = 7'h7F.
  - Active-low polarity constants.
- One natural sub-module: hex_to_seg7, purely combinational, 4-bit in and 7-bit out. It is instantiated once, after the digit mux.

Test Plan:
- Reset held 3 cycles mid-scan with a pending load -> an = 4'hF, seg7 = 7'h7F, dp = 1 during reset. After release, digit 0 shows 0 (seg7 = 7'h40, an = 4'hE) and the pending value never appears.
- SCAN_DIV = 4, load din = 16'h12AF -> no change until the frame boundary. Then an sequences E, D, B, 7 every 4 cycles with seg7 0E, 08, 24, 79. frame_start pulses every 16 cycles.
- Two loads in one frame, 16'h1111 then 16'h2222 -> the next frame shows only 2222 (seg7 = 7'h24 on every digit). A load on the boundary cycle is displayed one frame later.
- blank_lz = 1, din = 16'h0050 -> digits 3 and 2 show 7'h7F, digit 1 shows 12 and digit 0 shows 40. din = 16'h0000 -> only digit 0 shows 40.
- dp_in = 4'b0100 -> dp = 0 only while an = 4'hB. Combined with blanking of digit 2, dp = 1.
- BLINK_LOG2 = 1, blink_en = 1 -> an alternates 2 frames scanning and 2 frames all-ones. Dropping blink_en restores scanning on the next cycle.
